// File: rtl/led_mode_sequencer_if.sv
// rtl/led_mode_sequencer_if.sv - button/hold inputs and mode-select outputs of the LED mode sequencer
interface led_mode_sequencer_if;
  logic       button;
  logic       hold;
  logic [1:0] sel;
  logic       mode_step;
  logic       auto_active;

  modport master (
    output button,
    output hold,
    input  sel,
    input  mode_step,
    input  auto_active
  );

  modport slave (
    input  button,
    input  hold,
    output sel,
    output mode_step,
    output auto_active
  );
endinterface

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - push-button debounce, short/long press timing and LED mode stepping
// Optional automatic mode cycling (AUTO state, dwell timer, hold) is enabled by SEL_AUTO_CYCLE_EN.
module led_mode_sequencer #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int LONG_BITS     = 24,
  parameter int DWELL_BITS    = 24
) (
  input  logic                 clock,
  input  logic                 reset_n,
  led_mode_sequencer_if.slave  bus
);

  logic                     sync_1;
  logic                     bsync;
  logic                     db;
  logic                     db_prev;
  logic                     long_done;
  logic [DEBOUNCE_BITS-1:0] dcnt;
  logic [LONG_BITS-1:0]     pcnt;
  logic [1:0]               sel_q;
  logic                     step_q;
  logic                     db_fall;
  logic                     short_press;
  logic                     long_event;
  logic                     advance;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      bsync  <= 1'b0;
    end else begin
      sync_1 <= bus.button;
      bsync  <= sync_1;
    end
  end

  // db only follows bsync after it has disagreed for a full window of consecutive cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dcnt    <= '0;
      db      <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      db_prev <= db;
      if (bsync == db) begin
        dcnt <= '0;
      end else if (&dcnt) begin
        db   <= bsync;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DEBOUNCE_BITS'(1);
      end
    end
  end

  assign db_fall     = db_prev & ~db;
  assign short_press = db_fall & ~long_done;
  assign long_event  = db & (&pcnt) & ~long_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt      <= '0;
      long_done <= 1'b0;
    end else begin
      if (!db) begin
        pcnt <= '0;
      end else if (!(&pcnt)) begin
        pcnt <= pcnt + LONG_BITS'(1);
      end
      if (db_fall) begin
        long_done <= 1'b0;
      end else if (long_event) begin
        long_done <= 1'b1;
      end
    end
  end

`ifdef SEL_AUTO_CYCLE_EN
  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  state_t                state;
  state_t                state_next;
  logic [DWELL_BITS-1:0] wcnt;
  logic                  dwell_expire;
  logic                  auto_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= MANUAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (long_event) begin
      state_next = (state == MANUAL) ? AUTO : MANUAL;
    end
  end

  always_comb begin
    auto_q       = (state == AUTO);
    dwell_expire = (state == AUTO) & (&wcnt) & ~bus.hold;
    advance      = short_press | dwell_expire;
  end

  // Dwell count wraps on expiry; a short press restarts it, hold freezes it in place
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
    end else if (state != AUTO || long_event || short_press) begin
      wcnt <= '0;
    end else if (!bus.hold) begin
      wcnt <= wcnt + DWELL_BITS'(1);
    end
  end

  assign bus.auto_active = auto_q;
`else
  assign advance         = short_press;
  assign bus.auto_active = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= 2'b00;
      step_q <= 1'b0;
    end else begin
      sel_q  <= sel_q + 2'(advance);
      step_q <= advance;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.mode_step = step_q;

endmodule
